// File: rtl/bus_init_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_init_pkg
// Purpose  : Shared types and constants for the bus_initiator block:
//            FSM state encoding, the registered command record and the
//            default read-timeout length.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package bus_init_pkg;

  // Default number of read ACCESS cycles allowed before a timeout error.
  localparam int BUS_INIT_TIMEOUT_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Command as captured on acceptance; drives the bus for the whole access.
  typedef struct packed {
    logic       we;
    logic [9:0] addr;
    logic       rs0;
    logic       cs1;
    logic [7:0] wdata;
  } cmd_t;

endpackage : bus_init_pkg
`default_nettype wire

// File: rtl/bus_initiator.sv
`default_nettype none
// ============================================================================
// Module   : bus_initiator
// Purpose  : Converts valid/ready commands into single peripheral bus
//            accesses (write: one cycle; read: wait for bus_oe up to TIMEOUT
//            cycles) and returns a valid/ready response.
// Ports    : phi2, rst_n              - clock, async active-low reset
//            cmd_valid/ready/we/addr/rs0/cs1/wdata - command channel
//            rsp_valid/ready/rdata/err             - response channel
//            bus_we_n/a/di/rs0/cs1   - peripheral control outputs
//            bus_do/bus_oe           - peripheral read data and valid
// Revision : 1.0 - initial release
// ============================================================================
module bus_initiator
  import bus_init_pkg::*;
#(
  parameter int TIMEOUT = BUS_INIT_TIMEOUT_DEFAULT
) (
  input  logic       phi2,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_we,
  input  logic [9:0] cmd_addr,
  input  logic       cmd_rs0,
  input  logic       cmd_cs1,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       bus_we_n,
  output logic [9:0] bus_a,
  output logic [7:0] bus_di,
  output logic       bus_rs0,
  output logic       bus_cs1,
  input  logic [7:0] bus_do,
  input  logic       bus_oe
);

  // Counter only has to reach TIMEOUT-1, so it can never wrap before expiry.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  cmd_t             cmd_q, cmd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             err_q, err_d;

  always_ff @(posedge phi2 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          cmd_d.we    = cmd_we;
          cmd_d.addr  = cmd_addr;
          cmd_d.rs0   = cmd_rs0;
          cmd_d.cs1   = cmd_cs1;
          cmd_d.wdata = cmd_wdata;
          cnt_d       = '0;
          state_d     = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (cmd_q.we) begin
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (bus_oe) begin
          rdata_d = bus_do;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          // TIMEOUT-th ACCESS edge without bus_oe
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus is driven from the captured command only while in ACCESS; every
  // other state presents idle values so the peripheral sees no selection.
  always_comb begin
    bus_we_n = 1'b1;
    bus_a    = '0;
    bus_di   = '0;
    bus_rs0  = 1'b0;
    bus_cs1  = 1'b0;
    if (state_q == ST_ACCESS) begin
      bus_we_n = ~cmd_q.we;
      bus_a    = cmd_q.addr;
      bus_di   = cmd_q.wdata;
      bus_rs0  = cmd_q.rs0;
      bus_cs1  = cmd_q.cs1;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule : bus_initiator
`default_nettype wire
